// File: rtl/edge_event_detector.sv
// Multi-channel edge detector: synchronise, glitch-filter and report rise/fall pulses,
// with mode-selected events feeding per-channel sticky flags and a shared saturating counter.
module edge_event_detector #(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    sig,
  input  logic [1:0]       mode,
  input  logic [CH-1:0]    clr,
  input  logic             cnt_clr,
  output logic [CH-1:0]    level,
  output logic [CH-1:0]    pe,
  output logic [CH-1:0]    ne,
  output logic [CH-1:0]    ev,
  output logic             ev_any,
  output logic [CH-1:0]    sticky,
  output logic [CNT_W-1:0] ev_cnt
);

  localparam int unsigned FC_W  = $clog2(FILT_CYC + 1);
  localparam int unsigned PC_W  = $clog2(CH + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    s;
  logic [FC_W-1:0]  fc [CH];
  logic [PC_W-1:0]  ev_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  // Plain flop chain; no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(SYNC_STAGES); j++) sync_q[j] <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int j = 1; j < int'(SYNC_STAGES); j++) sync_q[j] <= sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level change is accepted only after FILT_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CH); i++) fc[i] <= '0;
      level <= '0;
      pe    <= '0;
      ne    <= '0;
    end else begin
      pe <= '0;
      ne <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        if (s[i] == level[i]) begin
          fc[i] <= '0;
        end else if (fc[i] == FC_LAST) begin
          level[i] <= s[i];
          fc[i]    <= '0;
          pe[i]    <= s[i];
          ne[i]    <= ~s[i];
        end else begin
          fc[i] <= fc[i] + FC_W'(1);
        end
      end
    end
  end

  assign ev     = (pe & {CH{mode[0]}}) | (ne & {CH{mode[1]}});
  assign ev_any = |ev;

  always_comb begin
    ev_pop = '0;
    for (int i = 0; i < int'(CH); i++) ev_pop = ev_pop + PC_W'(ev[i]);
  end

  // Widened add then clamp; a clear still keeps this cycle's events.
  always_comb begin
    cnt_sum = (cnt_clr ? '0 : SUM_W'(ev_cnt)) + SUM_W'(ev_pop);
    cnt_nxt = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
      ev_cnt <= '0;
    end else begin
      sticky <= ev | (sticky & ~clr);
      ev_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_detector.sv
// Directed self-checking bench for edge_event_detector at default parameters.
module tb_edge_event_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sig;
  logic [1:0] mode;
  logic [7:0] clr;
  logic       cnt_clr;
  logic [7:0] level, pe, ne, ev, sticky, ev_cnt;
  logic       ev_any;

  int checks = 0;
  int failures = 0;

  edge_event_detector dut (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
    .level(level), .pe(pe), .ne(ne), .ev(ev), .ev_any(ev_any),
    .sticky(sticky), .ev_cnt(ev_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = '0; mode = 2'b00; clr = '0; cnt_clr = 1'b0;
    tick(3);
    checks++; if (level !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", level); end
    checks++; if ({pe, ne} !== 16'h0) begin failures++; $display("FAIL reset_pulses got=%h exp=0000", {pe, ne}); end
    checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL reset_sticky got=%h exp=00", sticky); end
    checks++; if (ev_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ev_cnt); end
    checks++; if (ev_any !== 1'b0) begin failures++; $display("FAIL reset_ev_any got=%b exp=0", ev_any); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_rise();
    mode = 2'b01;
    sig[0] = 1'b1;
    tick(5);
    checks++; if (level !== 8'h00) begin failures++; $display("FAIL rise_early_level got=%h exp=00", level); end
    tick(1);
    checks++; if (level !== 8'h01) begin failures++; $display("FAIL rise_level got=%h exp=01", level); end
    checks++; if (pe !== 8'h01 || ne !== 8'h00) begin failures++; $display("FAIL rise_pe_ne got=%h/%h exp=01/00", pe, ne); end
    checks++; if (ev !== 8'h01 || ev_any !== 1'b1) begin failures++; $display("FAIL rise_ev got=%h/%b exp=01/1", ev, ev_any); end
    checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL rise_sticky_early got=%h exp=00", sticky); end
    tick(1);
    checks++; if (pe !== 8'h00) begin failures++; $display("FAIL rise_pe_one_cycle got=%h exp=00", pe); end
    checks++; if (sticky !== 8'h01) begin failures++; $display("FAIL rise_sticky got=%h exp=01", sticky); end
    checks++; if (ev_cnt !== 8'd1) begin failures++; $display("FAIL rise_cnt got=%0d exp=1", ev_cnt); end
  endtask

  task automatic test_glitch();
    sig[1] = 1'b1;
    tick(3);
    sig[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++; if (pe !== 8'h00 || ne !== 8'h00) begin failures++; $display("FAIL glitch_pulse got=%h/%h exp=00/00", pe, ne); end
    end
    checks++; if (level !== 8'h01) begin failures++; $display("FAIL glitch_level got=%h exp=01", level); end
    checks++; if (ev_cnt !== 8'd1) begin failures++; $display("FAIL glitch_cnt got=%0d exp=1", ev_cnt); end
  endtask

  task automatic test_modes();
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    checks++; if (ev_cnt !== 8'd0) begin failures++; $display("FAIL mode_cnt_clr got=%0d exp=0", ev_cnt); end
    mode = 2'b11;
    sig[2] = 1'b1; tick(6);
    checks++; if (pe !== 8'h04 || ev !== 8'h04) begin failures++; $display("FAIL both_rise got=%h/%h exp=04/04", pe, ev); end
    tick(4);
    sig[2] = 1'b0; tick(6);
    checks++; if (ne !== 8'h04 || ev !== 8'h04) begin failures++; $display("FAIL both_fall got=%h/%h exp=04/04", ne, ev); end
    tick(4);
    checks++; if (ev_cnt !== 8'd2) begin failures++; $display("FAIL both_cnt got=%0d exp=2", ev_cnt); end
    mode = 2'b01;
    sig[2] = 1'b1; tick(6);
    checks++; if (ev !== 8'h04) begin failures++; $display("FAIL rise_only_pe got=%h exp=04", ev); end
    mode = 2'b10; #1;
    checks++; if (ev !== 8'h00 || ev_any !== 1'b0) begin failures++; $display("FAIL mode_switch_ev got=%h/%b exp=00/0", ev, ev_any); end
    checks++; if (pe !== 8'h04) begin failures++; $display("FAIL mode_switch_pe got=%h exp=04", pe); end
    mode = 2'b01; #1;
    tick(4);
    sig[2] = 1'b0; tick(6);
    checks++; if (ne !== 8'h04 || ev !== 8'h00) begin failures++; $display("FAIL rise_only_ne got=%h/%h exp=04/00", ne, ev); end
    tick(4);
    checks++; if (ev_cnt !== 8'd3) begin failures++; $display("FAIL rise_only_cnt got=%0d exp=3", ev_cnt); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b01;
    sig = 8'h00; tick(10);
    checks++; if (level !== 8'h00 || ev_cnt !== 8'd3) begin failures++; $display("FAIL b2b_prep got=%h/%0d exp=00/3", level, ev_cnt); end
    sig = 8'hFF; tick(6);
    checks++; if (ev !== 8'hFF || ev_any !== 1'b1) begin failures++; $display("FAIL b2b_ev got=%h/%b exp=ff/1", ev, ev_any); end
    tick(1);
    checks++; if (ev_cnt !== 8'd11) begin failures++; $display("FAIL b2b_cnt got=%0d exp=11", ev_cnt); end
    sig = 8'h00; tick(10);
    sig = 8'hFF; tick(6);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    checks++; if (ev_cnt !== 8'd8) begin failures++; $display("FAIL b2b_clr_cnt got=%0d exp=8", ev_cnt); end
  endtask

  task automatic test_saturate();
    mode = 2'b11;
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    for (int t = 0; t < 31; t++) begin
      sig = ~sig; tick(8);
    end
    checks++; if (ev_cnt !== 8'd248) begin failures++; $display("FAIL sat_248 got=%0d exp=248", ev_cnt); end
    sig = 8'h03; tick(8);
    checks++; if (ev_cnt !== 8'd250) begin failures++; $display("FAIL sat_250 got=%0d exp=250", ev_cnt); end
    mode = 2'b00; sig = 8'h00; tick(8);
    checks++; if (ev_cnt !== 8'd250) begin failures++; $display("FAIL sat_mode_none got=%0d exp=250", ev_cnt); end
    mode = 2'b01; sig = 8'hFF; tick(8);
    checks++; if (ev_cnt !== 8'd255) begin failures++; $display("FAIL sat_clamp got=%0d exp=255", ev_cnt); end
    mode = 2'b11; sig = 8'h00; tick(8);
    checks++; if (ev_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", ev_cnt); end
  endtask

  task automatic test_sticky_reset();
    mode = 2'b01;
    clr = 8'hFF; tick(1); clr = 8'h00;
    checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL sticky_clr_all got=%h exp=00", sticky); end
    sig[3] = 1'b1; tick(6);
    checks++; if (ev !== 8'h08) begin failures++; $display("FAIL sticky_ev got=%h exp=08", ev); end
    clr = 8'h08; tick(1); clr = 8'h00;
    checks++; if (sticky !== 8'h08) begin failures++; $display("FAIL sticky_set_wins got=%h exp=08", sticky); end
    tick(2);
    clr = 8'h08; tick(1); clr = 8'h00;
    checks++; if (sticky !== 8'h00) begin failures++; $display("FAIL sticky_clr got=%h exp=00", sticky); end
    sig[4] = 1'b1; tick(4);
    rst = 1'b1; tick(1);
    checks++; if (level !== 8'h00 || pe !== 8'h00 || ne !== 8'h00) begin failures++; $display("FAIL rst_mid_lvl got=%h/%h/%h exp=00/00/00", level, pe, ne); end
    checks++; if (sticky !== 8'h00 || ev_cnt !== 8'd0) begin failures++; $display("FAIL rst_mid_state got=%h/%0d exp=00/0", sticky, ev_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (level !== 8'h00 || pe !== 8'h00) begin failures++; $display("FAIL rst_latency got=%h/%h exp=00/00", level, pe); end
    end
    tick(1);
    checks++; if (level !== 8'h18 || pe !== 8'h18) begin failures++; $display("FAIL rst_release_pe got=%h/%h exp=18/18", level, pe); end
    tick(1);
    checks++; if (ev_cnt !== 8'd2 || sticky !== 8'h18) begin failures++; $display("FAIL rst_release_cnt got=%0d/%h exp=2/18", ev_cnt, sticky); end
  endtask

  initial begin
    sig = '0; mode = '0; clr = '0; cnt_clr = 1'b0; rst = 1'b1;
    test_reset();
    test_rise();
    test_glitch();
    test_modes();
    test_back_to_back();
    test_saturate();
    test_sticky_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
